// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL), one register stage per shift-amount bit, valid/ready on both sides.
// Define BSHIFT_CARRY_EN to add the carry_out port and the per-stage carry registers.
module barrel_shift_pipe #(
    parameter int WIDTH = 8,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [SW-1:0]    sel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BSHIFT_CARRY_EN
    output logic [WIDTH-1:0] out,
    output logic             carry_out
`else
    output logic [WIDTH-1:0] out
`endif
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } shift_mode_t;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("barrel_shift_pipe: WIDTH must be a power of 2 and at least 2");
    end

    logic [SW-1:0]    v;
    logic [WIDTH-1:0] d_q   [SW];
    logic [SW-1:0]    s_q   [SW];
    shift_mode_t      m_q   [SW];

    logic [SW-1:0]    v_src;
    logic [WIDTH-1:0] d_src [SW];
    logic [SW-1:0]    s_src [SW];
    shift_mode_t      m_src [SW];
    logic [WIDTH-1:0] d_nxt [SW];
    logic [SW:0]      rdy;

`ifdef BSHIFT_CARRY_EN
    logic             c_q   [SW];
    logic             c_src [SW];
    logic             c_nxt [SW];
`endif

    function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                    input shift_mode_t m,
                                                    input int amt);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            MODE_LSL: r = d << amt;
            MODE_LSR: r = d >> amt;
            MODE_ASR: r = $unsigned($signed(d) >>> amt);
            MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
            default:  r = d;
        endcase
        return r;
    endfunction

`ifdef BSHIFT_CARRY_EN
    // The carry is the last bit to leave the word, taken before the shift; for ROL it is the bit that wrapped to bit 0.
    function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                         input logic [WIDTH-1:0] shifted,
                                         input shift_mode_t m,
                                         input int amt);
        logic [WIDTH-1:0] t;
        logic             c;
        t = '0;
        c = 1'b0;
        case (m)
            MODE_LSL: begin
                t = d << (amt - 1);
                c = t[WIDTH-1];
            end
            MODE_LSR, MODE_ASR: begin
                t = d >> (amt - 1);
                c = t[0];
            end
            MODE_ROL: c = shifted[0];
            default:  c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    // A stage can take new contents if it is empty or everything after it will move; written
    // without self-reference so the chain stays a plain combinational cone.
    always_comb begin
        rdy = '0;
        rdy[SW] = out_ready;
        for (int k = 0; k < SW; k++) begin
            rdy[k] = out_ready;
            for (int j = k; j < SW; j++) begin
                if (!v[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    // Each stage is fed by its predecessor, stage 0 by the input port.
    always_comb begin
        v_src    = '0;
        v_src[0] = in_valid;
        d_src[0] = data;
        s_src[0] = sel;
        m_src[0] = shift_mode_t'(mode);
`ifdef BSHIFT_CARRY_EN
        c_src[0] = 1'b0;
`endif
        for (int k = 1; k < SW; k++) begin
            v_src[k] = v[k-1];
            d_src[k] = d_q[k-1];
            s_src[k] = s_q[k-1];
            m_src[k] = m_q[k-1];
`ifdef BSHIFT_CARRY_EN
            c_src[k] = c_q[k-1];
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < SW; k++) begin
            d_nxt[k] = d_src[k];
`ifdef BSHIFT_CARRY_EN
            c_nxt[k] = c_src[k];
`endif
            if (s_src[k][k]) begin
                d_nxt[k] = shift_data(d_src[k], m_src[k], 1 << k);
`ifdef BSHIFT_CARRY_EN
                c_nxt[k] = shift_carry(d_src[k], d_nxt[k], m_src[k], 1 << k);
`endif
            end
        end
    end

    // Payload only loads with a valid source so bubbles never disturb the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < SW; k++) begin
                d_q[k] <= '0;
                s_q[k] <= '0;
                m_q[k] <= MODE_LSL;
`ifdef BSHIFT_CARRY_EN
                c_q[k] <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (rdy[k]) begin
                    v[k] <= v_src[k];
                    if (v_src[k]) begin
                        d_q[k] <= d_nxt[k];
                        s_q[k] <= s_src[k];
                        m_q[k] <= m_src[k];
`ifdef BSHIFT_CARRY_EN
                        c_q[k] <= c_nxt[k];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[SW-1];
    assign out       = d_q[SW-1];
`ifdef BSHIFT_CARRY_EN
    assign carry_out = c_q[SW-1];
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH = 8): the driver queues hand-computed results,
// and the monitor pops and compares them whenever an output transfer happens.
module tb_barrel_shift_pipe;

    localparam int WIDTH = 8;
    localparam int SW    = 3;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] data      = '0;
    logic [SW-1:0]    sel       = '0;
    logic [1:0]       mode      = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             carry_out;

    typedef struct {
        logic [7:0] out;
        logic       carry;
        int         acc_cyc;
        bit         chk_lat;
        bit         chk_consec;
        string      name;
    } exp_t;

    exp_t sb[$];

    int         n_checks      = 0;
    int         n_fail        = 0;
    int         cyc           = 0;
    int         accepts       = 0;
    int         stall_accepts = -1;
    int         last_xfer     = 0;
    bit         held          = 1'b0;
    logic [7:0] held_out      = '0;
    logic       held_carry    = 1'b0;

    barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .sel       (sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BSHIFT_CARRY_EN
        .out       (out),
        .carry_out (carry_out)
`else
        .out       (out)
`endif
    );

`ifndef BSHIFT_CARRY_EN
    assign carry_out = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; holds the operand until accepted, then queues the expected result.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                                 input logic [7:0] eo, input logic ec,
                                 input bit lat, input bit consec, input string name);
        exp_t e;
        int   budget;
        data     = d;
        sel      = s;
        mode     = m;
        in_valid = 1'b1;
        budget   = 0;
        #1;
        while (!in_ready) begin
            if (stall_accepts < 0) stall_accepts = accepts;
            budget++;
            if (budget > 50) begin
                checkOutput({name, " accept timeout"}, {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        e.out        = eo;
        e.carry      = ec;
        e.acc_cyc    = cyc;
        e.chk_lat    = lat;
        e.chk_consec = consec;
        e.name       = name;
        sb.push_back(e);
        accepts++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: samples mid-low-phase, where out_ready and the pipeline state are settled for the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, " out"}, {24'd0, out}, {24'd0, e.out});
`ifdef BSHIFT_CARRY_EN
                    checkOutput({e.name, " carry_out"}, {31'd0, carry_out}, {31'd0, e.carry});
`endif
                    if (e.chk_lat)
                        checkOutput({e.name, " latency"}, cyc - e.acc_cyc, 32'd3);
                    if (e.chk_consec)
                        checkOutput({e.name, " consecutive"}, cyc - last_xfer, 32'd1);
                end
                last_xfer = cyc;
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    checkOutput("stalled out stable", {24'd0, out}, {24'd0, held_out});
                    checkOutput("stalled carry stable", {31'd0, carry_out}, {31'd0, held_carry});
                end
                held_out   = out;
                held_carry = carry_out;
                held       = 1'b1;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        int budget;
        $display("[TB] barrel_shift_pipe bench start");
        #1;
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset out", {24'd0, out}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset carry_out", {31'd0, carry_out}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Mode sweep plus rotate/arith boundary amounts.
        applyStimulus(8'hA5, 3'd3, 2'b00, 8'h28, 1'b1, 1, 0, "LSL3");
        applyStimulus(8'hA5, 3'd1, 2'b01, 8'h52, 1'b1, 1, 0, "LSR1");
        applyStimulus(8'hA5, 3'd2, 2'b10, 8'hE9, 1'b0, 1, 0, "ASR2");
        applyStimulus(8'hA5, 3'd4, 2'b11, 8'h5A, 1'b0, 1, 0, "ROL4");
        applyStimulus(8'h01, 3'd7, 2'b11, 8'h80, 1'b0, 1, 0, "ROL7");
        applyStimulus(8'h7F, 3'd7, 2'b10, 8'h00, 1'b1, 1, 0, "ASR7");
        repeat (5) @(negedge clk);

        // sel sweep, back-to-back.
        applyStimulus(8'hA5, 3'd0, 2'b00, 8'hA5, 1'b0, 1, 0, "SEL0");
        applyStimulus(8'hA5, 3'd1, 2'b00, 8'h4A, 1'b1, 1, 1, "SEL1");
        applyStimulus(8'hA5, 3'd2, 2'b00, 8'h94, 1'b0, 1, 1, "SEL2");
        applyStimulus(8'hA5, 3'd3, 2'b00, 8'h28, 1'b1, 1, 1, "SEL3");
        applyStimulus(8'hA5, 3'd4, 2'b00, 8'h50, 1'b0, 1, 1, "SEL4");
        applyStimulus(8'hA5, 3'd5, 2'b00, 8'hA0, 1'b0, 1, 1, "SEL5");
        applyStimulus(8'hA5, 3'd6, 2'b00, 8'h40, 1'b1, 1, 1, "SEL6");
        applyStimulus(8'hA5, 3'd7, 2'b00, 8'h80, 1'b0, 1, 1, "SEL7");
        repeat (6) @(negedge clk);

        // Backpressure: 5 operands, consumer stalled for 6 cycles.
        out_ready     = 1'b0;
        accepts       = 0;
        stall_accepts = -1;
        fork
            begin
                applyStimulus(8'h81, 3'd1, 2'b11, 8'h03, 1'b1, 0, 0, "BP1");
                applyStimulus(8'h80, 3'd7, 2'b10, 8'hFF, 1'b0, 0, 1, "BP2");
                applyStimulus(8'h3C, 3'd2, 2'b01, 8'h0F, 1'b0, 0, 1, "BP3");
                applyStimulus(8'hFF, 3'd7, 2'b00, 8'h80, 1'b1, 0, 1, "BP4");
                applyStimulus(8'hF0, 3'd4, 2'b01, 8'h0F, 1'b0, 0, 1, "BP5");
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        checkOutput("in_ready fell after accepts", stall_accepts, 32'd3);
        repeat (8) @(negedge clk);

        // Bubble collapse: A, idle cycle, B, consumer stalled.
        out_ready = 1'b0;
        applyStimulus(8'h96, 3'd3, 2'b10, 8'hF2, 1'b1, 0, 0, "BUBA");
        @(negedge clk);
        applyStimulus(8'h0F, 3'd6, 2'b11, 8'hC3, 1'b1, 0, 1, "BUBB");
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with two operands in flight.
        out_ready = 1'b0;
        applyStimulus(8'h11, 3'd1, 2'b00, 8'h22, 1'b0, 0, 0, "RST1");
        applyStimulus(8'h22, 3'd1, 2'b00, 8'h44, 1'b0, 0, 0, "RST2");
        repeat (3) @(negedge clk);
        #3;
        checkOutput("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async reset out", {24'd0, out}, 32'd0);
        checkOutput("async reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("async reset carry_out", {31'd0, carry_out}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(8'hC3, 3'd0, 2'b01, 8'hC3, 1'b0, 1, 0, "POSTRST");

        budget = 0;
        while (sb.size() > 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("scoreboard drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
